// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array drain and requantisation logic.
package sa_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Wide working width for requant arithmetic; comfortably covers 49-bit products.
    localparam int unsigned CALC_BITS = 64;
    localparam int unsigned SHIFT_W   = 5;

    // Largest value representable in a signed field of the given width.
    function automatic logic signed [CALC_BITS-1:0] out_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic logic signed [CALC_BITS-1:0] out_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // Clamp a wide signed value into a signed field of the given width.
    function automatic logic signed [CALC_BITS-1:0] sat_int(input logic signed [CALC_BITS-1:0] value,
                                                            input int unsigned width);
        logic signed [CALC_BITS-1:0] hi;
        logic signed [CALC_BITS-1:0] lo;
        hi = out_max(width);
        lo = out_min(width);
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

    // Arithmetic right shift with round-half-up (ties toward +inf); shift 0 is identity.
    function automatic logic signed [CALC_BITS-1:0] round_shift(input logic signed [CALC_BITS-1:0] value,
                                                                input logic [SHIFT_W-1:0] shift);
        if (shift == SHIFT_W'(0)) return value;
        return (value + (64'sd1 <<< (shift - SHIFT_W'(1)))) >>> shift;
    endfunction

endpackage

// File: rtl/sa_requant_pipe.sv
// Three-stage requantisation pipe: multiply, round-shift + zero point, saturate.
module sa_requant_pipe
    import sa_pkg::*;
#(
    parameter int unsigned COLS       = 4,
    parameter int unsigned ACC_BITS   = 32,
    parameter int unsigned OUT_BITS   = 8,
    parameter int unsigned MULT_BITS  = 16,
    parameter int unsigned SHIFT_BITS = 5,
    localparam int unsigned IDX_BITS  = $clog2(COLS)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        stall,
    input  logic                        in_valid,
    input  logic signed [ACC_BITS-1:0]  in_acc,
    input  logic [IDX_BITS-1:0]         in_idx,
    input  logic [MULT_BITS-1:0]        mult,
    input  logic [SHIFT_BITS-1:0]       shift,
    input  logic signed [OUT_BITS-1:0]  zp,
    output logic                        m_valid,
    output logic signed [OUT_BITS-1:0]  m_data,
    output logic [IDX_BITS-1:0]         m_idx,
    output logic                        m_last
);

    localparam int unsigned PROD_BITS = ACC_BITS + MULT_BITS + 1;
    localparam int unsigned SUM_BITS  = PROD_BITS + 1;

    logic                        s1_valid;
    logic signed [PROD_BITS-1:0] s1_prod;
    logic [IDX_BITS-1:0]         s1_idx;
    logic                        s1_last;
    logic                        s2_valid;
    logic signed [SUM_BITS-1:0]  s2_sum;
    logic [IDX_BITS-1:0]         s2_idx;
    logic                        s2_last;

    logic signed [PROD_BITS-1:0] prod_c;
    logic signed [CALC_BITS-1:0] rnd_c;
    logic signed [CALC_BITS-1:0] sum_c;
    logic signed [CALC_BITS-1:0] sat_c;
    logic                        in_last_c;

    assign in_last_c = (in_idx == IDX_BITS'(COLS - 1));
    assign prod_c    = PROD_BITS'(in_acc) * $signed(PROD_BITS'({1'b0, mult}));
    assign rnd_c     = round_shift(CALC_BITS'(s1_prod), SHIFT_W'(shift));
    assign sum_c     = rnd_c + CALC_BITS'(zp);
    assign sat_c     = sat_int(CALC_BITS'(s2_sum), OUT_BITS);

    // Stage 1: exact signed x unsigned product.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_idx   <= '0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prod <= prod_c;
                s1_idx  <= in_idx;
                s1_last <= in_last_c;
            end
        end
    end

    // Stage 2: rounding shift and zero-point offset, one guard bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_idx   <= '0;
            s2_last  <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum  <= SUM_BITS'(sum_c);
                s2_idx  <= s1_idx;
                s2_last <= s1_last;
            end
        end
    end

    // Stage 3: saturate into the output register; holds while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_idx   <= '0;
            m_last  <= 1'b0;
        end else if (!stall) begin
            m_valid <= s2_valid;
            if (s2_valid) begin
                m_data <= OUT_BITS'(sat_c);
                m_idx  <= s2_idx;
                m_last <= s2_last;
            end
        end
    end

endmodule

// File: rtl/sa_acc_drain.sv
// Captures a row of int32 accumulators and streams them out requantised to int8.
module sa_acc_drain
    import sa_pkg::*;
#(
    parameter int unsigned COLS       = 4,
    parameter int unsigned ACC_BITS   = 32,
    parameter int unsigned OUT_BITS   = 8,
    parameter int unsigned MULT_BITS  = 16,
    parameter int unsigned SHIFT_BITS = 5,
    localparam int unsigned IDX_BITS  = $clog2(COLS)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cap_valid,
    output logic                        cap_ready,
    input  logic [COLS*ACC_BITS-1:0]    acc_in,
    input  logic [MULT_BITS-1:0]        scale_mult,
    input  logic [SHIFT_BITS-1:0]       scale_shift,
    input  logic signed [OUT_BITS-1:0]  zero_point,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [OUT_BITS-1:0]  m_data,
    output logic [IDX_BITS-1:0]         m_idx,
    output logic                        m_last,
    output logic                        busy
);

    drain_state_t               state_q;
    drain_state_t               state_nxt;
    logic signed [ACC_BITS-1:0] cap_acc [COLS];
    logic [MULT_BITS-1:0]       cap_mult;
    logic [SHIFT_BITS-1:0]      cap_shift;
    logic signed [OUT_BITS-1:0] cap_zp;
    logic [IDX_BITS-1:0]        issue_idx;
    logic                       issue_done;

    logic cap_fire_c;
    logic issue_valid_c;
    logic issue_fire_c;
    logic stall_c;

    assign stall_c      = m_valid && !m_ready;
    assign issue_fire_c = issue_valid_c && !stall_c;

    // Next-state and issue control.
    always_comb begin
        state_nxt     = state_q;
        cap_fire_c    = 1'b0;
        issue_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_valid && cap_ready) begin
                    cap_fire_c = 1'b1;
                    state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                issue_valid_c = !issue_done;
                if (m_valid && m_ready && m_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cap_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cap_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt == DRAIN);
        end
    end

    // Capture buffer and issue counter; scale settings frozen for the whole drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned c = 0; c < COLS; c++) cap_acc[c] <= '0;
            cap_mult   <= '0;
            cap_shift  <= '0;
            cap_zp     <= '0;
            issue_idx  <= '0;
            issue_done <= 1'b1;
        end else if (cap_fire_c) begin
            for (int unsigned c = 0; c < COLS; c++) cap_acc[c] <= acc_in[c*ACC_BITS +: ACC_BITS];
            cap_mult   <= scale_mult;
            cap_shift  <= scale_shift;
            cap_zp     <= zero_point;
            issue_idx  <= '0;
            issue_done <= 1'b0;
        end else if (issue_fire_c) begin
            if (issue_idx == IDX_BITS'(COLS - 1)) issue_done <= 1'b1;
            else                                  issue_idx  <= issue_idx + IDX_BITS'(1);
        end
    end

    sa_requant_pipe #(
        .COLS       (COLS),
        .ACC_BITS   (ACC_BITS),
        .OUT_BITS   (OUT_BITS),
        .MULT_BITS  (MULT_BITS),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .stall    (stall_c),
        .in_valid (issue_fire_c),
        .in_acc   (cap_acc[issue_idx]),
        .in_idx   (issue_idx),
        .mult     (cap_mult),
        .shift    (cap_shift),
        .zp       (cap_zp),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_idx    (m_idx),
        .m_last   (m_last)
    );

endmodule

// File: tb/tb_sa_acc_drain.sv
// Directed bench for sa_acc_drain with a scoreboard of expected beats.
module tb_sa_acc_drain;

    logic               clk;
    logic               rstn;
    logic               cap_valid;
    logic               cap_ready;
    logic [127:0]       acc_in;
    logic [15:0]        scale_mult;
    logic [4:0]         scale_shift;
    logic signed [7:0]  zero_point;
    logic               m_valid;
    logic               m_ready;
    logic signed [7:0]  m_data;
    logic [1:0]         m_idx;
    logic               m_last;
    logic               busy;

    typedef struct {
        int data;
        int idx;
        bit last;
    } beat_t;

    beat_t        sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] alt_acc;
    int           cyc;
    int           lat;

    sa_acc_drain dut (
        .clk         (clk),
        .rstn        (rstn),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .acc_in      (acc_in),
        .scale_mult  (scale_mult),
        .scale_shift (scale_shift),
        .zero_point  (zero_point),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_idx       (m_idx),
        .m_last      (m_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference requantisation using floor division rather than shifts.
    function automatic int model(input int acc, input int mult, input int shift, input int zp);
        longint p;
        longint d;
        longint num;
        longint q;
        p = longint'(acc) * longint'(mult);
        if (shift == 0) begin
            q = p;
        end else begin
            d   = longint'(1) << shift;
            num = p + d / 2;
            q   = num / d;
            if ((num % d != 0) && (num < 0)) q = q - 1;
        end
        q = q + longint'(zp);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    // Drive a capture request at the current negedge and queue its expected beats.
    task automatic capture(input int a0, input int a1, input int a2, input int a3,
                           input int mult, input int shift, input int zp);
        int a [4];
        beat_t b;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        acc_in      = {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
        scale_mult  = 16'(mult);
        scale_shift = 5'(shift);
        zero_point  = 8'(zp);
        cap_valid   = 1'b1;
        chk("cap_ready_idle", 64'(cap_ready), 64'(1));
        for (int c = 0; c < 4; c++) begin
            b.data = model(a[c], mult, shift, zp);
            b.idx  = c;
            b.last = (c == 3);
            sb.push_back(b);
        end
        @(negedge clk);
        cap_valid = 1'b0;
        chk("busy_after_cap", 64'(busy), 64'(1));
        chk("cap_ready_after_cap", 64'(cap_ready), 64'(0));
        chk("m_valid_after_cap", 64'(m_valid), 64'(0));
    endtask

    // Consume beats against the scoreboard, optionally stalling one beat or pulsing cap_valid.
    task automatic drain(input int hold_beat, input int hold_cycles, input bit inject,
                         input int stop_after, output int cycles, output int first_lat);
        int popped;
        int held;
        int it;
        beat_t e;
        popped = 0; held = 0; it = 0; first_lat = -1;
        while (sb.size() > 0 && popped < stop_after) begin
            @(negedge clk);
            it++;
            if (it > 40) begin
                chk("drain_timeout_beats_left", 64'(sb.size()), 64'(0));
                sb.delete();
                break;
            end
            if (inject) begin
                cap_valid = 1'b1;
                acc_in    = alt_acc;
            end
            m_ready = !(m_valid && popped == hold_beat && held < hold_cycles);
            if (m_valid) begin
                if (first_lat < 0) first_lat = it;
                e = sb[0];
                chk("beat_data", 64'(m_data), 64'(e.data));
                chk("beat_idx",  64'(m_idx),  64'(e.idx));
                chk("beat_last", 64'(m_last), 64'(e.last));
                if (m_ready) begin
                    void'(sb.pop_front());
                    popped++;
                end else begin
                    held++;
                end
            end
        end
        cycles  = it;
        m_ready = 1'b1;
    endtask

    task automatic expect_idle();
        @(negedge clk);
        chk("idle_cap_ready", 64'(cap_ready), 64'(1));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_m_valid", 64'(m_valid), 64'(0));
    endtask

    initial begin
        rstn        = 1'b0;
        cap_valid   = 1'b0;
        m_ready     = 1'b1;
        acc_in      = '0;
        scale_mult  = '0;
        scale_shift = '0;
        zero_point  = '0;
        alt_acc     = {32'(-64), 32'(63), 32'(50), 32'(-1000)};
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_m_idx", 64'(m_idx), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cap_ready", 64'(cap_ready), 64'(1));
        rstn = 1'b1;
        @(negedge clk);

        // Identity scale with saturation on both ends.
        capture(100, 200, -300, -128, 1, 0, 0);
        drain(-1, 0, 1'b0, 4, cyc, lat);
        chk("first_latency", 64'(lat), 64'(3));
        chk("drain_cycles", 64'(cyc), 64'(6));
        expect_idle();

        // Rounding ties toward +inf.
        capture(3, -3, 5, -5, 1, 1, 0);
        drain(-1, 0, 1'b0, 4, cyc, lat);
        expect_idle();
        capture(3, -3, 5, -5, 1, 2, 0);
        drain(-1, 0, 1'b0, 4, cyc, lat);
        expect_idle();

        // Scale, shift and negative zero point.
        capture(10, -40, 1000, 0, 3, 2, -20);
        drain(-1, 0, 1'b0, 4, cyc, lat);
        expect_idle();

        // Backpressure on beat 1 for two cycles.
        capture(10, -40, 1000, 0, 3, 2, -20);
        drain(1, 2, 1'b0, 4, cyc, lat);
        chk("bp_drain_cycles", 64'(cyc), 64'(8));
        expect_idle();

        // cap_valid held with new data through the drain: ignored until idle.
        capture(7, 8, 9, 10, 2, 1, 3);
        drain(-1, 0, 1'b1, 4, cyc, lat);
        chk("inject_drain_cycles", 64'(cyc), 64'(6));
        @(negedge clk);
        chk("inject_idle_busy", 64'(busy), 64'(0));
        capture(-1000, 50, 63, -64, 2, 1, 3);
        drain(-1, 0, 1'b0, 4, cyc, lat);
        chk("alt_first_latency", 64'(lat), 64'(3));
        expect_idle();

        // Asynchronous reset in the middle of a drain.
        capture(1, 2, 3, 4, 5, 0, 0);
        drain(-1, 0, 1'b0, 2, cyc, lat);
        @(negedge clk);
        chk("pre_reset_m_valid", 64'(m_valid), 64'(1));
        rstn = 1'b0;
        #1;
        chk("reset_m_valid", 64'(m_valid), 64'(0));
        chk("reset_cap_ready", 64'(cap_ready), 64'(1));
        chk("reset_busy", 64'(busy), 64'(0));
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_m_valid", 64'(m_valid), 64'(0));
        capture(-7, 77, 1234, -999, 1, 3, 5);
        drain(-1, 0, 1'b0, 4, cyc, lat);
        chk("post_reset_cycles", 64'(cyc), 64'(6));
        expect_idle();

        // A few random vectors with arbitrary scale settings.
        for (int t = 0; t < 4; t++) begin
            capture(int'($urandom), int'($urandom_range(0, 2000)) - 1000,
                    int'($urandom), int'($urandom_range(0, 70000)) - 35000,
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 255)) - 128);
            drain(t % 4, t, 1'b0, 4, cyc, lat);
            expect_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
